load_store_unit: RTL

- Data-memory access stage of the multicycle MIPS datapath; sits directly upstream of the load sign-extension stage.
- Takes one load/store request from the control unit and runs one Avalon-MM transaction: byte enables, store lane replication, waitrequest stalls.
- Returns the load lane right-aligned and zero-extended, plus a size select that drives the sign extender's `data_readdata`/`select` inputs.

---
 rtl/load_store_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory access stage of the multicycle MIPS datapath. Accepts one
// load/store request, runs a single Avalon-MM transaction and returns the
// load lane right-aligned and zero-extended, with a size select for the
// downstream sign extender.
//
// Optional feature macro: UNALIGNED_LWLR_EN
//   defined   : ops 5 (LWL) and 6 (LWR) are valid word reads at any alignment
//   undefined : ops 5/6 are rejected with resp_error
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   req_write, req_op       store flag, access size / LWL / LWR
//   req_addr                byte address
//   req_wdata, req_rt_old   store data, current rt for LWL/LWR merge
//   resp_valid              one-cycle completion pulse
//   resp_rdata              aligned load data
//   resp_select             0 = byte, 1 = half/word (sign extender select)
//   resp_error              request rejected, qualified by resp_valid
//   avm_*                   Avalon-MM master
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_rt_old,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_select,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [3:0]            avm_byteenable,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest
);

    localparam logic [2:0] OP_BYTE = 3'd0;
    localparam logic [2:0] OP_HALF = 3'd1;
    localparam logic [2:0] OP_WORD = 3'd2;
`ifdef UNALIGNED_LWLR_EN
    localparam logic [2:0] OP_LWL  = 3'd5;
    localparam logic [2:0] OP_LWR  = 3'd6;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic                    write_q;
    logic [2:0]              op_q;
    logic [1:0]              k_q;
`ifdef UNALIGNED_LWLR_EN
    logic [31:0]             rt_q;
`else
    logic                    unused_rt_c;
`endif
    logic                    resp_valid_q;
    logic [31:0]             resp_rdata_q;
    logic                    resp_select_q;
    logic                    resp_error_q;
    logic                    avm_read_q;
    logic                    avm_write_q;
    logic [ADDR_WIDTH-1:0]   avm_address_q;
    logic [3:0]              avm_byteenable_q;
    logic [31:0]             avm_writedata_q;

    logic                    req_err_c;
    logic [3:0]              be_c;
    logic [31:0]             wdata_c;
    logic [31:0]             load_data_c;
    logic                    load_select_c;

`ifndef UNALIGNED_LWLR_EN
    // rt is only consumed by the LWL/LWR merge
    assign unused_rt_c = ^req_rt_old;
`endif

    // Request decode: validity, lane enables and lane-replicated store data
    always_comb begin
        req_err_c = 1'b0;
        be_c      = 4'h0;
        wdata_c   = req_wdata;
        case (req_op)
            OP_BYTE: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            OP_HALF: begin
                be_c      = 4'b0011 << req_addr[1:0];
                wdata_c   = {2{req_wdata[15:0]}};
                req_err_c = req_addr[0];
            end
            OP_WORD: begin
                be_c      = 4'hF;
                req_err_c = |req_addr[1:0];
            end
`ifdef UNALIGNED_LWLR_EN
            OP_LWL, OP_LWR: begin
                be_c      = 4'hF;
                req_err_c = req_write;
            end
`endif
            default: req_err_c = 1'b1;
        endcase
    end

    // Load lane extraction / LWL-LWR merge from the bus word
    always_comb begin
        load_data_c   = avm_readdata;
        load_select_c = 1'b1;
        case (op_q)
            OP_BYTE: begin
                load_data_c   = 32'(avm_readdata[{k_q, 3'b000} +: 8]);
                load_select_c = 1'b0;
            end
            OP_HALF: load_data_c = 32'(avm_readdata[{k_q[1], 4'b0000} +: 16]);
`ifdef UNALIGNED_LWLR_EN
            // A 6-bit shift of 32 clears the rt mask when k = 3
            OP_LWL: load_data_c = (avm_readdata << {~k_q, 3'b000})
                                | (rt_q & (32'hFFFF_FFFF >> (6'({k_q, 3'b000}) + 6'd8)));
            OP_LWR: load_data_c = (avm_readdata >> {k_q, 3'b000})
                                | (rt_q & ~(32'hFFFF_FFFF >> {k_q, 3'b000}));
`endif
            default: load_data_c = avm_readdata;
        endcase
    end

    // Control FSM with registered response and bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            write_q          <= 1'b0;
            op_q             <= 3'd0;
            k_q              <= 2'd0;
`ifdef UNALIGNED_LWLR_EN
            rt_q             <= 32'd0;
`endif
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'd0;
            resp_select_q    <= 1'b0;
            resp_error_q     <= 1'b0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_byteenable_q <= 4'h0;
            avm_writedata_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        op_q    <= req_op;
                        k_q     <= req_addr[1:0];
`ifdef UNALIGNED_LWLR_EN
                        rt_q    <= req_rt_old;
`endif
                        if (req_err_c) begin
                            // Rejected: straight to the response, bus untouched
                            state_q       <= ST_DONE;
                            resp_valid_q  <= 1'b1;
                            resp_error_q  <= 1'b1;
                            resp_rdata_q  <= 32'd0;
                            resp_select_q <= 1'b0;
                        end else begin
                            state_q          <= ST_BUS;
                            avm_read_q       <= ~req_write;
                            avm_write_q      <= req_write;
                            avm_address_q    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            avm_byteenable_q <= be_c;
                            avm_writedata_q  <= wdata_c;
                        end
                    end
                end
                ST_BUS: begin
                    if (!avm_waitrequest) begin
                        state_q       <= ST_DONE;
                        avm_read_q    <= 1'b0;
                        avm_write_q   <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        resp_error_q  <= 1'b0;
                        resp_rdata_q  <= write_q ? 32'd0 : load_data_c;
                        resp_select_q <= write_q ? 1'b0 : load_select_c;
                    end
                end
                ST_DONE: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready      = ~reset & (state_q == ST_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_select    = resp_select_q;
    assign resp_error     = resp_error_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_byteenable = avm_byteenable_q;
    assign avm_writedata  = avm_writedata_q;

endmodule
